nonce_select: RTL
=================

NONCE_SELECT -- requirements
Module: nonce_select

Interface
REQ-001 The block SHALL have parameter NUM_NONCES, default 16, giving the number of consecutive hash words to scan (legal range 1..255).
REQ-002 The block SHALL have port clk, input, 1 bit: clock.
REQ-003 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: begin a scan, sampled only in IDLE.
REQ-005 The block SHALL have port hash_addr, input, 16 bits: base address of the hash words (H0 of nonce 0..NUM_NONCES-1).
REQ-006 The block SHALL have port result_addr, input, 16 bits: base address of the 2-word result record.
REQ-007 The block SHALL have port target, input, 32 bits: unsigned difficulty threshold.
REQ-008 The block SHALL have port done, output, 1 bit: scan complete.
REQ-009 The block SHALL have ports mem_clk (output, 1), mem_we (output, 1), mem_addr (output, 16), mem_write_data (output, 32) and mem_read_data (input, 32): shared single-port memory interface.

Function
REQ-010 mem_clk SHALL equal clk; memory read data for the address driven in cycle c SHALL be valid in cycle c+1.
REQ-011 The FSM SHALL have states IDLE, READ, DRAIN, WRITE0, WRITE1 and DONE.
REQ-012 In IDLE with start=1, the block SHALL latch hash_addr, result_addr and target, clear the min/hit trackers, and enter READ; start in any other state SHALL be ignored.
REQ-013 READ SHALL last exactly NUM_NONCES cycles, driving mem_addr = hash_addr+k (k=0..NUM_NONCES-1, one per cycle) with mem_we=0, then enter DRAIN.
REQ-014 DRAIN SHALL last 1 cycle; it receives the last read word.
REQ-015 Each returned word k SHALL be compared unsigned. If word < best_hash or k=0, then best_hash=word and best_nonce=k. Ties SHALL keep the lower index.
REQ-016 Each returned word strictly less than target SHALL set found=1 and increment hit_count (8 bits, saturating at 255).
REQ-017 WRITE0 SHALL drive mem_we=1, mem_addr=result_addr, mem_write_data=best_hash.
REQ-018 WRITE1 SHALL drive mem_we=1, mem_addr=result_addr+1, mem_write_data={found, 15'b0, hit_count[7:0], best_nonce[7:0]}.
REQ-019 DONE SHALL drive mem_we=0 and done=1 for exactly one cycle, then return to IDLE.
REQ-020 Latency: with start sampled at edge 0, done SHALL be high in cycle NUM_NONCES+4 (20 for the default).
REQ-021 Address arithmetic SHALL be 16-bit modulo; hash_addr+k and result_addr+1 wrap from 0xFFFF to 0x0000.
REQ-022 target=0 SHALL yield found=0 and hit_count=0; target=0xFFFFFFFF SHALL count every word except 0xFFFFFFFF.
REQ-023 Inputs hash_addr, result_addr and target changing after start is accepted SHALL have no effect on the current scan.
REQ-024 mem_we SHALL be 1 only in WRITE0 and WRITE1.

Reset
REQ-025 reset_n low SHALL asynchronously force state=IDLE, done=0, mem_we=0, mem_addr=0, mem_write_data=0, best_hash=0, best_nonce=0, hit_count=0 and found=0.
REQ-026 Reset asserted mid-scan SHALL abort the scan with no further memory writes; the first start after reset release SHALL run a complete fresh scan.

Verification
REQ-027 Scenario: NUM_NONCES=16, hashes 0x10000000+k, target=0x10000003 -> result_addr=0x10000000, result_addr+1=0x80000300, done in cycle 20.
REQ-028 Scenario: all 16 hashes=0xFFFFFFFF, target=0xFFFFFFFF -> best_hash=0xFFFFFFFF, word1=0x00000000.
REQ-029 Scenario: hashes equal 0x00000005 at k=3 and k=9 (minimum), all others 0x00000100, target=0x00000006 -> best_nonce=3, word1=0x80000203.
REQ-030 Scenario: hash_addr=0xFFF8, result_addr=0xFFFF -> reads wrap to 0x0000..0x0007; the writes land at 0xFFFF and 0x0000.
REQ-031 Scenario: start pulsed during READ, then reset_n pulsed low at READ cycle 5 -> no writes occur, done stays 0; a new start runs a full 20-cycle scan.
REQ-032 Scenario: NUM_NONCES=1, hash=0x00000000, target=0x00000001 -> word0=0x00000000, word1=0x80000100, done in cycle 5.

Source files
------------

// File: rtl/nonce_select.sv
// Scans NUM_NONCES hash words and writes the lowest hash, its index and the hit count into a result record.
// done is high NUM_NONCES+4 cycles after start is sampled; there is no backpressure and start is ignored while busy.
module nonce_select #(
    parameter int NUM_NONCES = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] hash_addr,
    input  logic [15:0] result_addr,
    input  logic [31:0] target,
    output logic        done,
    output logic        mem_clk,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ   = 3'd1,
        DRAIN  = 3'd2,
        WRITE0 = 3'd3,
        WRITE1 = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(NUM_NONCES - 1);

    state_t      state;
    state_t      state_nxt;

    logic [15:0] hash_base;
    logic [15:0] result_base;
    logic [31:0] target_q;
    logic [7:0]  rd_idx;
    logic        cmp_vld;
    logic [7:0]  cmp_idx;
    logic [31:0] best_hash;
    logic [7:0]  best_nonce;
    logic [7:0]  hit_count;
    logic        found;

    assign mem_clk = clk;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = READ;
            READ:    if (rd_idx == LAST_IDX) state_nxt = DRAIN;
            DRAIN:   state_nxt = WRITE0;
            WRITE0:  state_nxt = WRITE1;
            WRITE1:  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        done           = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = 16'h0000;
        mem_write_data = 32'h0000_0000;
        case (state)
            READ: begin
                mem_addr = hash_base + {8'h00, rd_idx};
            end
            WRITE0: begin
                mem_we         = 1'b1;
                mem_addr       = result_base;
                mem_write_data = best_hash;
            end
            WRITE1: begin
                mem_we         = 1'b1;
                mem_addr       = result_base + 16'd1;
                mem_write_data = {found, 15'b0, hit_count, best_nonce};
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                done = 1'b0;
            end
        endcase
    end

    // Read data lags the address by one cycle, so the compare stage carries the index of the word now arriving.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hash_base   <= 16'h0000;
            result_base <= 16'h0000;
            target_q    <= 32'h0000_0000;
            rd_idx      <= 8'h00;
            cmp_vld     <= 1'b0;
            cmp_idx     <= 8'h00;
            best_hash   <= 32'h0000_0000;
            best_nonce  <= 8'h00;
            hit_count   <= 8'h00;
            found       <= 1'b0;
        end else begin
            cmp_vld <= (state == READ);
            cmp_idx <= rd_idx;

            if (state == IDLE && start) begin
                hash_base   <= hash_addr;
                result_base <= result_addr;
                target_q    <= target;
                rd_idx      <= 8'h00;
                best_hash   <= 32'h0000_0000;
                best_nonce  <= 8'h00;
                hit_count   <= 8'h00;
                found       <= 1'b0;
            end else if (state == READ) begin
                rd_idx <= rd_idx + 8'd1;
            end

            if (cmp_vld) begin
                // Strict less-than keeps the earlier index on ties.
                if (cmp_idx == 8'h00 || mem_read_data < best_hash) begin
                    best_hash  <= mem_read_data;
                    best_nonce <= cmp_idx;
                end
                if (mem_read_data < target_q) begin
                    found <= 1'b1;
                    if (hit_count != 8'hFF) begin
                        hit_count <= hit_count + 8'd1;
                    end
                end
            end
        end
    end

endmodule
